imem_responder: RTL and testbench

Instruction-memory responder that serves the fetch stage's PC requests. It accepts a PC through a valid/ready request port and reads a synchronous word-addressed instruction RAM. Each instruction is returned with its PC through a valid/ready response port, buffered by a small FIFO so decode back-pressure never drops a word. A flush input discards every in-flight and buffered response when fetch redirects on a taken branch.

---
 rtl/imem_responder_pkg.sv | 19 +
 rtl/imem_rsp_fifo.sv | 68 ++++++
 rtl/imem_responder.sv | 107 ++++++++++
 tb/tb_imem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_responder_pkg;

   // Instruction substituted for any misaligned fetch (addi x0, x0, 0).
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // One response as it travels through the buffer and out to decode.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        misaligned;
   } imem_rsp_t;

   // A PC is misaligned when it does not point at a 32-bit word boundary.
   function automatic logic is_misaligned(input logic [1:0] pc_lo);
      return pc_lo != 2'b00;
   endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Small synchronous response FIFO with push, pop, flush and an occupancy count.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module imem_rsp_fifo
   import imem_responder_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  imem_rsp_t       push_data,
   input  logic            pop,
   input  logic            flush,
   output imem_rsp_t       head,
   output logic            valid,
   output logic [CW-1:0]   count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   imem_rsp_t     store [DEPTH];
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A push into a full buffer is only taken when the head leaves the same cycle.
   assign do_push = push && !flush && ((count != CW'(DEPTH)) || pop);
   assign do_pop  = pop && (count != '0);

   // Pointer and count bookkeeping; flush empties the buffer at the edge.
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Entry storage.
   // NOTE: these few entries are flops and are reset so the head reads zero out of reset;
   // the large instruction RAM in the top level is deliberately left unreset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) store[i] <= '0;
      end else if (do_push) begin
         store[wr_ptr] <= push_data;
      end
   end

   assign head  = store[rd_ptr];
   assign valid = (count != '0);

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetch PCs, reads a synchronous
// word-addressed RAM, and returns {instr, pc, misaligned} through a small
// FIFO so decode back-pressure never drops a word. Flush discards all
// outstanding responses except a request accepted in the flush cycle.
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter  int MEM_WORDS  = 1024,
   parameter  int FIFO_DEPTH = 2,
   localparam int AW         = $clog2(MEM_WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [31:0]   req_pc,
   input  logic          flush,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_instr,
   output logic [31:0]   rsp_pc,
   output logic          rsp_misaligned,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [31:0]   mem [MEM_WORDS];
   logic [31:0]   ram_rdata;
   logic          s1_valid;
   logic [31:0]   s1_pc;
   logic          s1_misaligned;
   logic          accept;
   logic          pop;
   logic          push;
   imem_rsp_t     push_data;
   imem_rsp_t     head;
   logic          fifo_valid;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   occupancy;

   assign accept = req_valid && req_ready;
   assign pop    = rsp_valid && rsp_ready;

   // Accept only when the entry in flight will still fit after this cycle's pop.
   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      occupancy = '0;
      req_ready = 1'b0;
      occupancy = {1'b0, fifo_count} + (CW+1)'(s1_valid);
      req_ready = rst && !load_en &&
                  ((occupancy - (CW+1)'(pop)) < (CW+1)'(FIFO_DEPTH));
   end

   // Program-load write port; RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (load_en) mem[load_addr] <= load_data;
   end

   // Synchronous read port; upper PC bits are ignored so addresses wrap.
   always_ff @(posedge clk) begin
      if (accept) ram_rdata <= mem[req_pc[AW+1:2]];
   end

   // Read stage: a request accepted during flush is the redirect target and is kept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid      <= 1'b0;
         s1_pc         <= '0;
         s1_misaligned <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_pc         <= req_pc;
            s1_misaligned <= is_misaligned(req_pc[1:0]);
         end
      end
   end

   // The stale read-stage entry is dropped on flush rather than pushed.
   assign push                 = s1_valid && !flush;
   assign push_data.instr      = s1_misaligned ? NOP_INSTR : ram_rdata;
   assign push_data.pc         = s1_pc;
   assign push_data.misaligned = s1_misaligned;

   imem_rsp_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .valid     (fifo_valid),
      .count     (fifo_count)
   );

   assign rsp_valid      = fifo_valid;
   assign rsp_instr      = head.instr;
   assign rsp_pc         = head.pc;
   assign rsp_misaligned = head.misaligned;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever decode consumes one.
module tb_imem_responder;
   import imem_responder_pkg::*;

   localparam int MEM_WORDS  = 1024;
   localparam int FIFO_DEPTH = 2;
   localparam int AW         = $clog2(MEM_WORDS);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [31:0]   req_pc = '0;
   logic          flush = 1'b0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [31:0]   rsp_instr;
   logic [31:0]   rsp_pc;
   logic          rsp_misaligned;
   logic          load_en = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [31:0]   load_data = '0;

   int n_vec  = 0;
   int n_fail = 0;

   imem_rsp_t   exp_q[$];
   logic [31:0] mem_model [MEM_WORDS];

   logic        rr_seen;
   logic        vld_seen;
   logic [31:0] pc_seen;
   logic [31:0] instr_seen;

   imem_responder #(
      .MEM_WORDS  (MEM_WORDS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_pc         (req_pc),
      .flush          (flush),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_instr      (rsp_instr),
      .rsp_pc         (rsp_pc),
      .rsp_misaligned (rsp_misaligned),
      .load_en        (load_en),
      .load_addr      (load_addr),
      .load_data      (load_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic imem_rsp_t expect_rsp(input logic [31:0] pc);
      imem_rsp_t r;
      r.pc         = pc;
      r.misaligned = (pc[1:0] != 2'b00);
      r.instr      = r.misaligned ? 32'h0000_0013 : mem_model[pc[AW+1:2]];
      return r;
   endfunction

   // Monitor: every consumed response must match the head of the scoreboard.
   always @(negedge clk) begin
      imem_rsp_t e;
      if (rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_rsp: got pc=%h instr=%h with nothing expected", rsp_pc, rsp_instr);
         end else begin
            e = exp_q.pop_front();
            check("rsp", {rsp_instr, rsp_pc, rsp_misaligned}, e);
         end
      end
   end

   // One clock of stimulus: drive after posedge, sample at negedge, then update the scoreboard.
   task automatic step(input logic v = 1'b0, input logic [31:0] pc = '0, input logic rr = 1'b1,
                       input logic fl = 1'b0, input logic le = 1'b0,
                       input logic [AW-1:0] la = '0, input logic [31:0] ld = '0);
      req_valid = v;  req_pc = pc;  rsp_ready = rr;  flush = fl;
      load_en = le;   load_addr = la;  load_data = ld;
      @(negedge clk);
      #1;
      rr_seen    = req_ready;
      vld_seen   = rsp_valid;
      pc_seen    = rsp_pc;
      instr_seen = rsp_instr;
      if (fl) exp_q.delete();
      if (v && req_ready) exp_q.push_back(expect_rsp(pc));
      if (le) mem_model[la] = ld;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 16) begin
         step(1'b0, 32'h0, 1'b1);
         n++;
      end
      check("drain_empty", 65'(exp_q.size()), 65'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      #1;
      check("rst_rsp_valid", 65'(rsp_valid), 65'd0);
      check("rst_req_ready", 65'(req_ready), 65'd0);
      check("rst_rsp_fields", {rsp_instr, rsp_pc, rsp_misaligned}, 65'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("post_rst_ready", 65'(req_ready), 65'd1);

      // Program load of mem[0..3]; req_ready must stay low while loading.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, AW'(i), 32'hA0 + 32'(i));
         check("load_blocks_req", 65'(rr_seen), 65'd0);
      end

      // Streaming with rsp_ready high: one response per cycle, latency one.
      step(1'b1, 32'h0, 1'b1);
      step(1'b1, 32'h4, 1'b1);
      check("lat_s1_only", 65'(vld_seen), 65'd0);
      step(1'b1, 32'h8, 1'b1);
      check("lat_first_rsp", 65'(vld_seen), 65'd1);
      step(1'b1, 32'hC, 1'b1);
      check("stream_vld1", 65'(vld_seen), 65'd1);
      step();
      check("stream_vld2", 65'(vld_seen), 65'd1);
      step();
      check("stream_vld3", 65'(vld_seen), 65'd1);
      check("stream_last_pc", 65'(pc_seen), 65'hC);
      step();
      check("stream_empty", 65'(vld_seen), 65'd0);

      // Stall: only two accepted, head held stable, release lets the third in.
      step(1'b1, 32'h0, 1'b0);
      step(1'b1, 32'h4, 1'b0);
      check("stall_acc2", 65'(rr_seen), 65'd1);
      step(1'b1, 32'h8, 1'b0);
      check("stall_full", 65'(rr_seen), 65'd0);
      check("stall_head", 65'(instr_seen), 65'hA0);
      step(1'b1, 32'h8, 1'b0);
      check("stall_hold", 65'(instr_seen), 65'hA0);
      check("stall_full2", 65'(rr_seen), 65'd0);
      step(1'b1, 32'h8, 1'b1);
      check("stall_release_acc", 65'(rr_seen), 65'd1);
      drain();

      // Flush with the redirect target accepted in the same cycle.
      step(1'b1, 32'h0, 1'b0);
      step(1'b1, 32'h4, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      check("flush_prefill_full", 65'(rr_seen), 65'd0);
      step(1'b1, 32'hC, 1'b1, 1'b1);
      check("flush_acc", 65'(rr_seen), 65'd1);
      step();
      check("flush_empty", 65'(vld_seen), 65'd0);
      step();
      check("flush_target_vld", 65'(vld_seen), 65'd1);
      check("flush_target_pc", 65'(pc_seen), 65'hC);
      drain();

      // Misaligned PC returns NOP; PC = 4*MEM_WORDS wraps to word 0.
      step(1'b1, 32'h6, 1'b1);
      step(1'b1, 32'(4 * MEM_WORDS), 1'b1);
      step();
      check("misaligned_instr", 65'(instr_seen), 65'h13);
      check("misaligned_pc", 65'(pc_seen), 65'h6);
      drain();

      // Load ordering: a read issued before the write returns the old word.
      step(1'b1, 32'h8, 1'b1);
      step(1'b1, 32'h8, 1'b1, 1'b0, 1'b1, AW'(2), 32'hB2);
      check("load_prio", 65'(rr_seen), 65'd0);
      step(1'b1, 32'h8, 1'b1);
      check("post_load_acc", 65'(rr_seen), 65'd1);
      drain();

      // Asynchronous reset with two entries buffered.
      step(1'b1, 32'h0, 1'b0);
      step(1'b1, 32'h4, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      check("pre_rst_vld", 65'(vld_seen), 65'd1);
      rst = 1'b0;
      #1;
      check("async_rst_vld", 65'(rsp_valid), 65'd0);
      check("async_rst_ready", 65'(req_ready), 65'd0);
      check("async_rst_pc", 65'(rsp_pc), 65'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      step(1'b1, 32'h0, 1'b1);
      check("rerst_acc", 65'(rr_seen), 65'd1);
      step();
      check("rerst_lat0", 65'(vld_seen), 65'd0);
      step();
      check("rerst_lat1", 65'(vld_seen), 65'd1);
      check("rerst_instr", 65'(instr_seen), 65'hA0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
